// File: rtl/rx_capture.sv
// rx_capture: frame-capture writer from the pixel-counter side into frame BRAM.
// Aligns capture to vertical sync (active low), decimates visible samples
// horizontally, truncates them to BRAM width and writes them to sequential
// addresses with a bounded depth and a sticky overflow flag.
// Optional feature macro: RX_CAPTURE_PINGPONG_EN -- alternate between two
// frame banks so the display side always reads the last complete frame.
module rx_capture #(
    parameter int DATA_W  = 10,
    parameter int OUT_W   = 8,
    parameter int ADDR_W  = 14,
    parameter int DEPTH   = 8192,
    parameter int H_DECIM = 1
) (
    input  logic              O_CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic              O_VS,
    input  logic              O_VISIBLE,
    input  logic [DATA_W-1:0] VIDEO,
    output logic [OUT_W-1:0]  BRAM_DIN,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic              BRAM_WE,
    output logic              FRAME_DONE,
    output logic              RD_BANK,
    output logic              OVERFLOW,
    output logic [7:0]        FRAME_COUNT
);

    typedef enum logic [1:0] {IDLE, ALIGN, SYNC, CAPTURE} state_t;

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      DEC_LAST = 4'(H_DECIM - 1);

    state_t          state;
    logic            vs_q;
    logic            vis_q;
    logic [3:0]      dec_cnt;
    logic [3:0]      dec_eff;
    logic [3:0]      dec_next;
    logic [ADDR_W:0] offset;
    logic [ADDR_W:0] addr_full;
    logic            wr_bank;
    logic            vs_fall;
    logic            vs_rise;
    logic            vis_rise;
    logic            qual;
    logic            do_write;
    logic            frame_end;
    logic            video_unused;

    // Only the top OUT_W bits of each sample are stored; the rest is dropped.
    assign video_unused = ^VIDEO;

    // Sync/visible edge detection, per-line decimation phase and write qualification.
    always_comb begin
        vs_fall   = vs_q & ~O_VS;
        vs_rise   = ~vs_q & O_VS;
        vis_rise  = O_VISIBLE & ~vis_q;
        // A visible rise restarts the decimation phase on the same cycle,
        // so the first sample of every line is always a candidate.
        dec_eff   = vis_rise ? 4'd0 : dec_cnt;
        dec_next  = dec_cnt;
        if (O_VISIBLE) begin
            dec_next = (dec_eff == DEC_LAST) ? 4'd0 : dec_eff + 4'd1;
        end
        // ENABLE gates the qualifier so a deassert stops writes on the next edge.
        qual      = ENABLE && (state == CAPTURE) && O_VISIBLE && O_VS && (dec_eff == 4'd0);
        do_write  = qual && (offset != DEPTH_L);
        frame_end = ENABLE && (state == CAPTURE) && vs_fall;
        addr_full = offset + (wr_bank ? DEPTH_L : '0);
    end

    // Capture FSM, offset/decimation counters and registered BRAM write port.
    always_ff @(posedge O_CLK) begin
        if (RST) begin
            state       <= IDLE;
            vs_q        <= 1'b1;
            vis_q       <= 1'b0;
            dec_cnt     <= 4'd0;
            offset      <= '0;
            BRAM_DIN    <= '0;
            BRAM_ADDR   <= '0;
            BRAM_WE     <= 1'b0;
            FRAME_DONE  <= 1'b0;
            OVERFLOW    <= 1'b0;
            FRAME_COUNT <= 8'd0;
        end else begin
            vs_q       <= O_VS;
            vis_q      <= O_VISIBLE;
            dec_cnt    <= dec_next;
            BRAM_WE    <= do_write;
            FRAME_DONE <= frame_end;
            if (do_write) begin
                BRAM_DIN  <= VIDEO[DATA_W-1 -: OUT_W];
                BRAM_ADDR <= addr_full[ADDR_W-1:0];
                offset    <= offset + (ADDR_W+1)'(1);
            end
            // A qualified sample with the bank already full is dropped and flagged.
            if (qual && !do_write) begin
                OVERFLOW <= 1'b1;
            end
            if (frame_end) begin
                FRAME_COUNT <= FRAME_COUNT + 8'd1;
            end
            if (!ENABLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= ALIGN;
                    ALIGN:   if (vs_fall) state <= SYNC;
                    SYNC: begin
                        if (vs_rise) begin
                            state   <= CAPTURE;
                            offset  <= '0;
                            dec_cnt <= 4'd0;
                        end
                    end
                    CAPTURE: if (vs_fall) state <= SYNC;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef RX_CAPTURE_PINGPONG_EN
    // Swap banks at each completed frame; RD_BANK names the bank just finished.
    always_ff @(posedge O_CLK) begin
        if (RST) begin
            wr_bank <= 1'b0;
            RD_BANK <= 1'b1;
        end else if (frame_end) begin
            wr_bank <= ~wr_bank;
            RD_BANK <= wr_bank;
        end
    end
`else
    assign wr_bank = 1'b0;
    assign RD_BANK = 1'b0;
`endif

endmodule

// File: tb/tb_rx_capture.sv
// tb_rx_capture: directed bench for rx_capture. Three instances share one
// stimulus: default parameters, H_DECIM=3, and DEPTH=16.
module tb_rx_capture;

`ifdef RX_CAPTURE_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif
    localparam logic RB_RST = PP;

    logic       clk = 1'b0;
    logic       rst, enable, vs, vis;
    logic [9:0] video;

    logic [7:0]  def_din, dec_din, ovf_din;
    logic [13:0] def_addr, dec_addr, ovf_addr;
    logic        def_we, dec_we, ovf_we;
    logic        def_fd, dec_fd, ovf_fd;
    logic        def_rb, dec_rb, ovf_rb;
    logic        def_ovf, dec_ovf, ovf_ovf;
    logic [7:0]  def_fc, dec_fc, ovf_fc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rx_capture u_def (
        .O_CLK(clk), .RST(rst), .ENABLE(enable), .O_VS(vs), .O_VISIBLE(vis), .VIDEO(video),
        .BRAM_DIN(def_din), .BRAM_ADDR(def_addr), .BRAM_WE(def_we), .FRAME_DONE(def_fd),
        .RD_BANK(def_rb), .OVERFLOW(def_ovf), .FRAME_COUNT(def_fc));

    rx_capture #(.H_DECIM(3)) u_dec (
        .O_CLK(clk), .RST(rst), .ENABLE(enable), .O_VS(vs), .O_VISIBLE(vis), .VIDEO(video),
        .BRAM_DIN(dec_din), .BRAM_ADDR(dec_addr), .BRAM_WE(dec_we), .FRAME_DONE(dec_fd),
        .RD_BANK(dec_rb), .OVERFLOW(dec_ovf), .FRAME_COUNT(dec_fc));

    rx_capture #(.DEPTH(16)) u_ovf (
        .O_CLK(clk), .RST(rst), .ENABLE(enable), .O_VS(vs), .O_VISIBLE(vis), .VIDEO(video),
        .BRAM_DIN(ovf_din), .BRAM_ADDR(ovf_addr), .BRAM_WE(ovf_we), .FRAME_DONE(ovf_fd),
        .RD_BANK(ovf_rb), .OVERFLOW(ovf_ovf), .FRAME_COUNT(ovf_fc));

    // Advance one clock; outputs are then stable and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; vs = 1'b1; vis = 1'b0; video = '0;
        tick();
        rst = 1'b0;
    endtask

    // IDLE->ALIGN, VS fall (ALIGN->SYNC), VS rise (SYNC->CAPTURE).
    task automatic start_frame();
        enable = 1'b1; vs = 1'b1; vis = 1'b0;
        tick();
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (def_din !== 8'h00) begin n_fail++; $display("FAIL reset_din: got %0h expected 0", def_din); end
        n_checks++; if (def_addr !== 14'd0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", def_addr); end
        n_checks++; if (def_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b expected 0", def_we); end
        n_checks++; if (def_fd !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %0b expected 0", def_fd); end
        n_checks++; if (def_rb !== RB_RST) begin n_fail++; $display("FAIL reset_rd_bank: got %0b expected %0b", def_rb, RB_RST); end
        n_checks++; if (def_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", def_ovf); end
        n_checks++; if (def_fc !== 8'd0) begin n_fail++; $display("FAIL reset_fc: got %0d expected 0", def_fc); end
    endtask

    task automatic test_basic();
        logic [9:0] vin [5];
        logic [7:0] dexp [5];
        vin  = '{10'h3FC, 10'h004, 10'h200, 10'h3FF, 10'h001};
        dexp = '{8'hFF, 8'h01, 8'h80, 8'hFF, 8'h00};
        do_reset();
        start_frame();
        n_checks++; if (def_we !== 1'b0) begin n_fail++; $display("FAIL basic_pre_we: got %0b expected 0", def_we); end
        for (int i = 0; i < 5; i++) begin
            vis = 1'b1; video = vin[i];
            tick();
            n_checks++; if (def_we !== 1'b1) begin n_fail++; $display("FAIL basic_we[%0d]: got %0b expected 1", i, def_we); end
            n_checks++; if (def_addr !== 14'(i)) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, def_addr, i); end
            n_checks++; if (def_din !== dexp[i]) begin n_fail++; $display("FAIL basic_din[%0d]: got %0h expected %0h", i, def_din, dexp[i]); end
        end
        vis = 1'b0;
        tick();
        n_checks++; if (def_we !== 1'b0) begin n_fail++; $display("FAIL basic_post_we: got %0b expected 0", def_we); end
    endtask

    task automatic test_decim();
        do_reset();
        start_frame();
        for (int ln = 0; ln < 2; ln++) begin
            for (int s = 0; s < 7; s++) begin
                vis = 1'b1; video = 10'((ln * 16 + s) * 4);
                tick();
                if (s % 3 == 0) begin
                    n_checks++; if (dec_we !== 1'b1) begin n_fail++; $display("FAIL decim_we[%0d.%0d]: got %0b expected 1", ln, s, dec_we); end
                    n_checks++; if (dec_addr !== 14'(ln * 3 + s / 3)) begin n_fail++; $display("FAIL decim_addr[%0d.%0d]: got %0d expected %0d", ln, s, dec_addr, ln * 3 + s / 3); end
                    n_checks++; if (dec_din !== 8'(ln * 16 + s)) begin n_fail++; $display("FAIL decim_din[%0d.%0d]: got %0h expected %0h", ln, s, dec_din, ln * 16 + s); end
                end else begin
                    n_checks++; if (dec_we !== 1'b0) begin n_fail++; $display("FAIL decim_skip[%0d.%0d]: got %0b expected 0", ln, s, dec_we); end
                end
            end
            vis = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_pingpong();
        do_reset();
        start_frame();
        for (int i = 0; i < 3; i++) begin
            vis = 1'b1; video = 10'(i * 4);
            tick();
        end
        vis = 1'b0; vs = 1'b0;
        tick();
        n_checks++; if (def_fd !== 1'b1) begin n_fail++; $display("FAIL pp_fd1: got %0b expected 1", def_fd); end
        n_checks++; if (def_fc !== 8'd1) begin n_fail++; $display("FAIL pp_fc1: got %0d expected 1", def_fc); end
        n_checks++; if (def_rb !== 1'b0) begin n_fail++; $display("FAIL pp_rb1: got %0b expected 0", def_rb); end
        vs = 1'b1;
        tick();
        n_checks++; if (def_fd !== 1'b0) begin n_fail++; $display("FAIL pp_fd_one_cycle: got %0b expected 0", def_fd); end
        vis = 1'b1; video = 10'h2A8;
        tick();
        n_checks++; if (def_we !== 1'b1) begin n_fail++; $display("FAIL pp_we2: got %0b expected 1", def_we); end
        n_checks++; if (def_addr !== (PP ? 14'd8192 : 14'd0)) begin n_fail++; $display("FAIL pp_addr2: got %0d expected %0d", def_addr, PP ? 8192 : 0); end
        vis = 1'b0; vs = 1'b0;
        tick();
        n_checks++; if (def_rb !== PP) begin n_fail++; $display("FAIL pp_rb2: got %0b expected %0b", def_rb, PP); end
        n_checks++; if (def_fc !== 8'd2) begin n_fail++; $display("FAIL pp_fc2: got %0d expected 2", def_fc); end
        vs = 1'b1;
        tick();
        vis = 1'b1;
        tick();
        n_checks++; if (def_addr !== 14'd0) begin n_fail++; $display("FAIL pp_addr3: got %0d expected 0", def_addr); end
        vis = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        start_frame();
        for (int i = 0; i < 20; i++) begin
            vis = 1'b1; video = 10'(i * 4);
            tick();
            n_checks++; if (ovf_we !== (i < 16)) begin n_fail++; $display("FAIL ovf_we[%0d]: got %0b expected %0b", i, ovf_we, i < 16); end
            if (i < 16) begin
                n_checks++; if (ovf_addr !== 14'(i)) begin n_fail++; $display("FAIL ovf_addr[%0d]: got %0d expected %0d", i, ovf_addr, i); end
            end
            if (i == 15 || i == 16) begin
                n_checks++; if (ovf_ovf !== (i == 16)) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %0b expected %0b", i, ovf_ovf, i == 16); end
            end
        end
        vis = 1'b0; vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            vis = 1'b1;
            tick();
            n_checks++; if (ovf_addr !== 14'((PP ? 16 : 0) + i)) begin n_fail++; $display("FAIL ovf_next_addr[%0d]: got %0d expected %0d", i, ovf_addr, (PP ? 16 : 0) + i); end
            n_checks++; if (ovf_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky[%0d]: got %0b expected 1", i, ovf_ovf); end
        end
        do_reset();
        n_checks++; if (ovf_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_rst_clear: got %0b expected 0", ovf_ovf); end
    endtask

    task automatic test_enable();
        do_reset();
        start_frame();
        for (int i = 0; i < 100; i++) begin
            vis = 1'b1; video = 10'(i);
            tick();
        end
        n_checks++; if (def_addr !== 14'd99) begin n_fail++; $display("FAIL en_last_addr: got %0d expected 99", def_addr); end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (def_we !== 1'b0) begin n_fail++; $display("FAIL en_off_we[%0d]: got %0b expected 0", i, def_we); end
        end
        vis = 1'b0; vs = 1'b0;
        tick();
        n_checks++; if (def_fd !== 1'b0) begin n_fail++; $display("FAIL en_off_fd: got %0b expected 0", def_fd); end
        n_checks++; if (def_rb !== RB_RST) begin n_fail++; $display("FAIL en_off_rb: got %0b expected %0b", def_rb, RB_RST); end
        n_checks++; if (def_fc !== 8'd0) begin n_fail++; $display("FAIL en_off_fc: got %0d expected 0", def_fc); end
        vs = 1'b1;
        tick();
        enable = 1'b1; vis = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (def_we !== 1'b0) begin n_fail++; $display("FAIL en_realign_we[%0d]: got %0b expected 0", i, def_we); end
        end
        vis = 1'b0; vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        n_checks++; if (def_we !== 1'b0) begin n_fail++; $display("FAIL en_sync_we: got %0b expected 0", def_we); end
        vis = 1'b1; video = 10'h0F0;
        tick();
        n_checks++; if (def_we !== 1'b1) begin n_fail++; $display("FAIL en_restart_we: got %0b expected 1", def_we); end
        n_checks++; if (def_addr !== 14'd0) begin n_fail++; $display("FAIL en_restart_addr: got %0d expected 0", def_addr); end
        vis = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_frame();
        vis = 1'b1;
        tick();
        vis = 1'b0; vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            vis = 1'b1; video = 10'h3FC;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (def_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we: got %0b expected 0", def_we); end
        n_checks++; if (def_addr !== 14'd0) begin n_fail++; $display("FAIL rmid_addr: got %0d expected 0", def_addr); end
        n_checks++; if (def_din !== 8'h00) begin n_fail++; $display("FAIL rmid_din: got %0h expected 0", def_din); end
        n_checks++; if (def_fc !== 8'd0) begin n_fail++; $display("FAIL rmid_fc: got %0d expected 0", def_fc); end
        n_checks++; if (def_rb !== RB_RST) begin n_fail++; $display("FAIL rmid_rb: got %0b expected %0b", def_rb, RB_RST); end
        n_checks++; if (def_fd !== 1'b0) begin n_fail++; $display("FAIL rmid_fd: got %0b expected 0", def_fd); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (def_we !== 1'b0) begin n_fail++; $display("FAIL rmid_hold_we[%0d]: got %0b expected 0", i, def_we); end
        end
        vis = 1'b0; vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        vis = 1'b1;
        tick();
        n_checks++; if (def_we !== 1'b1) begin n_fail++; $display("FAIL rmid_restart_we: got %0b expected 1", def_we); end
        n_checks++; if (def_addr !== 14'd0) begin n_fail++; $display("FAIL rmid_restart_addr: got %0d expected 0", def_addr); end
        vis = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decim();
        test_pingpong();
        test_overflow();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
